// File: rtl/ret_addr_stack_pkg.sv
// Shared frontend definitions for the return-address stack.
// Holds the stored-entry layout, the next-PC-select bundle and the width
// helpers used to size the pointer and occupancy counter from DEPTH.
package ret_addr_stack_pkg;

    // Address width of the sv32 frontend configuration.
    localparam int unsigned RAS_VLEN = 32;

    // One stack slot: valid flag plus the stored return address.
    typedef struct packed {
        logic                valid;
        logic [RAS_VLEN-1:0] ra;
    } ras_entry_t;

    // Prediction bundle handed to the next-PC select logic.
    typedef struct packed {
        logic                valid;
        logic [RAS_VLEN-1:0] ra;
    } ras_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned ras_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Top-pointer width: at least one bit so DEPTH=1 still has a legal vector.
    function automatic int unsigned ras_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : ret_addr_stack_pkg

// File: rtl/ret_addr_stack.sv
// Return-address stack for the frontend branch predictor.
// Circular buffer of DEPTH {valid, addr} entries with a wrapping top pointer
// and a saturating occupancy counter. A push into a full stack silently
// replaces the oldest entry; a pop on an empty stack is a no-op. Both cases
// raise a one-cycle registered pulse.
//
// Ports:
//   clk_i       core clock
//   rst_i       asynchronous reset, active-high
//   flush_i     invalidate all entries (highest priority)
//   push_i      call detected; data_i becomes the new top
//   pop_i       return detected; remove the top
//   data_i      return address to push
//   data_o      current top-of-stack address (read from registers only)
//   valid_o     top-of-stack entry is valid
//   count_o     current occupancy, 0..DEPTH
//   overflow_o  one-cycle pulse: a push discarded the oldest entry
//   underflow_o one-cycle pulse: pop issued while empty
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [VLEN-1:0]             data_i,
    output logic [VLEN-1:0]             data_o,
    output logic                        valid_o,
    output logic [ras_cnt_w(DEPTH)-1:0] count_o,
    output logic                        overflow_o,
    output logic                        underflow_o
);

    localparam int unsigned PTR_W = ras_ptr_w(DEPTH);
    localparam int unsigned CNT_W = ras_cnt_w(DEPTH);

    // Storage slot sized by the instance's VLEN (package layout is the sv32 case).
    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] ra;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [PTR_W-1:0]   tp_q;
    logic [PTR_W-1:0]   tp_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               overflow_d;
    logic               underflow_d;

    logic [PTR_W-1:0]   tp_inc_c;
    logic [PTR_W-1:0]   tp_dec_c;
    logic               full_c;
    logic               empty_c;

    // Pointer neighbours with modulo-DEPTH wrap; DEPTH=1 pins the pointer at 0.
    always_comb begin
        tp_inc_c = '0;
        tp_dec_c = '0;
        if (DEPTH > 1) begin
            if (tp_q == PTR_W'(DEPTH - 1)) begin
                tp_inc_c = '0;
            end else begin
                tp_inc_c = tp_q + PTR_W'(1);
            end
            if (tp_q == '0) begin
                tp_dec_c = PTR_W'(DEPTH - 1);
            end else begin
                tp_dec_c = tp_q - PTR_W'(1);
            end
        end
    end

    assign full_c  = (cnt_q == CNT_W'(DEPTH));
    assign empty_c = (cnt_q == '0);

    // Next-state selection: flush > push&pop > push > pop.
    always_comb begin
        ent_d       = ent_q;
        tp_d        = tp_q;
        cnt_d       = cnt_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (flush_i) begin
            // Pointer is left where it is; only validity and occupancy reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            cnt_d = '0;
        end else if (push_i && pop_i) begin
            // Replace the top in place; an empty stack gains its first entry.
            ent_d[tp_q].valid = 1'b1;
            ent_d[tp_q].ra    = data_i;
            if (empty_c) begin
                cnt_d = CNT_W'(1);
            end
        end else if (push_i) begin
            ent_d[tp_inc_c].valid = 1'b1;
            ent_d[tp_inc_c].ra    = data_i;
            tp_d                  = tp_inc_c;
            // When full, the slot after the top is the oldest entry.
            if (full_c) begin
                overflow_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            if (empty_c) begin
                underflow_d = 1'b1;
            end else begin
                ent_d[tp_q].valid = 1'b0;
                tp_d              = tp_dec_c;
                cnt_d             = cnt_q - CNT_W'(1);
            end
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            tp_q        <= '0;
            cnt_q       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            tp_q        <= tp_d;
            cnt_q       <= cnt_d;
            overflow_o  <= overflow_d;
            underflow_o <= underflow_d;
        end
    end

    // Top-of-stack view comes straight from registers.
    assign data_o  = ent_q[tp_q].ra;
    assign valid_o = ent_q[tp_q].valid;
    assign count_o = cnt_q;

endmodule : ret_addr_stack
